// File: rtl/ddr_frame_reader.sv
// DDR read-side frame player: fetches 128-bit words and unpacks five 24-bit pixels per word.
// Optional macro LOOP_PLAYBACK_EN: replay the stored sequence continuously instead of returning to idle.
module ddr_frame_reader #(
  parameter int unsigned MAX_ADDRESS      = 39322,
  parameter int unsigned NUMBER_OF_PIXELS = 196608,
  parameter int unsigned PIXEL_WIDTH      = 20,
  parameter int unsigned NUMBER_OF_FRAMES = 226
) (
  input  logic          clk,
  input  logic          cpu_resetn,
  input  logic          end_of_write,
  input  logic          start,
  input  logic          rd_busy,
  input  logic          rd_data_valid,
  input  logic [127:0]  rd_data,
  output logic          rd_en,
  output logic [23:0]   rd_addr,
  output logic [23:0]   pixel_out,
  output logic          pixel_valid,
  input  logic          pixel_ready,
  output logic          end_of_frame,
  output logic          full_read_ready,
  output logic [8:0]    frame_number
);

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned PIX_W   = 24;
  localparam int unsigned FRAME_W = 9;
  localparam int unsigned LINE_W  = 3;
  localparam int unsigned WORD_W  = 5 * PIX_W;

  localparam logic [ADDR_W-1:0]      LAST_WORD  = ADDR_W'(MAX_ADDRESS - 1);
  localparam logic [PIXEL_WIDTH-1:0] LAST_PIXEL = PIXEL_WIDTH'(NUMBER_OF_PIXELS - 1);
  localparam logic [FRAME_W-1:0]     LAST_FRAME = FRAME_W'(NUMBER_OF_FRAMES - 1);
  localparam logic [LINE_W-1:0]      LAST_LINE  = LINE_W'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DATA,
    S_UNPACK
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;

  logic                     r_rd_en;
  logic [ADDR_W-1:0]        r_rd_addr;
  logic [PIX_W-1:0]         r_pixel_out;
  logic                     r_pixel_valid;
  logic                     r_full_read_ready;
  logic [FRAME_W-1:0]       r_frame_number;
  logic [WORD_W-1:0]        r_word;
  logic [ADDR_W-1:0]        r_word_idx;
  logic [LINE_W-1:0]        r_pixel_in_line;
  logic [PIXEL_WIDTH-1:0]   r_pixel_number;

  logic                     w_handshake;
  logic                     w_word_done;
  logic                     w_frame_done;
  logic                     w_seq_done;
  logic [LINE_W-1:0]        w_next_line;
  logic [PIX_W-1:0]         w_next_slice;
  logic                     w_unused_hi;

  // Byte 15 of each DDR word carries no pixel data.
  assign w_unused_hi = ^rd_data[127:120];

  assign w_handshake  = r_pixel_valid && pixel_ready;
  assign w_word_done  = w_handshake && ((r_pixel_in_line == LAST_LINE) || (r_pixel_number == LAST_PIXEL));
  assign w_frame_done = w_word_done && (r_word_idx == LAST_WORD);
  assign w_seq_done   = w_frame_done && (r_frame_number == LAST_FRAME);
  assign w_next_line  = r_pixel_in_line + LINE_W'(1);

  // Pixel presented after the current one is accepted.
  always_comb begin
    w_next_slice = '0;
    case (w_next_line)
      3'd1:    w_next_slice = r_word[47:24];
      3'd2:    w_next_slice = r_word[71:48];
      3'd3:    w_next_slice = r_word[95:72];
      3'd4:    w_next_slice = r_word[119:96];
      default: w_next_slice = '0;
    endcase
  end

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (end_of_write && start) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!rd_busy) begin
          w_state_next = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (rd_data_valid) begin
          w_state_next = S_UNPACK;
        end
      end
      S_UNPACK: begin
        if (w_word_done) begin
          if (w_seq_done) begin
`ifdef LOOP_PLAYBACK_EN
            w_state_next = S_ISSUE;
`else
            w_state_next = S_IDLE;
`endif
          end else begin
            w_state_next = S_ISSUE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Read request, word capture and pixel/frame bookkeeping.
  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_rd_en           <= 1'b0;
      r_rd_addr         <= '0;
      r_pixel_out       <= '0;
      r_pixel_valid     <= 1'b0;
      r_full_read_ready <= 1'b0;
      r_frame_number    <= '0;
      r_word            <= '0;
      r_word_idx        <= '0;
      r_pixel_in_line   <= '0;
      r_pixel_number    <= '0;
    end else begin
      r_rd_en           <= (r_state == S_ISSUE) && !rd_busy;
      r_full_read_ready <= w_seq_done;
      if ((r_state == S_WAIT_DATA) && rd_data_valid) begin
        r_word          <= rd_data[WORD_W-1:0];
        r_pixel_in_line <= '0;
        r_pixel_out     <= rd_data[PIX_W-1:0];
        r_pixel_valid   <= 1'b1;
      end else if (w_handshake) begin
        r_pixel_number  <= r_pixel_number + PIXEL_WIDTH'(1);
        r_pixel_in_line <= w_next_line;
        r_pixel_out     <= w_next_slice;
        if (w_word_done) begin
          r_pixel_valid <= 1'b0;
          r_rd_addr     <= r_rd_addr + ADDR_W'(1);
          r_word_idx    <= r_word_idx + ADDR_W'(1);
          if (w_frame_done) begin
            r_word_idx     <= '0;
            r_pixel_number <= '0;
            r_frame_number <= r_frame_number + FRAME_W'(1);
          end
          if (w_seq_done) begin
            r_frame_number <= '0;
            r_rd_addr      <= '0;
          end
        end
      end
    end
  end

  assign rd_en           = r_rd_en;
  assign rd_addr         = r_rd_addr;
  assign pixel_out       = r_pixel_out;
  assign pixel_valid     = r_pixel_valid;
  assign full_read_ready = r_full_read_ready;
  assign frame_number    = r_frame_number;
  assign end_of_frame    = r_pixel_valid && (r_pixel_number == LAST_PIXEL);

endmodule

// File: tb/tb_ddr_frame_reader.sv
// Bench for ddr_frame_reader: DDR read model feeding a pixel scoreboard, small frame geometry.
module tb_ddr_frame_reader;

  localparam int MA    = 3;
  localparam int NP    = 13;
  localparam int NF    = 2;
  localparam int PW    = 20;
  localparam int WORDS = MA * NF;

  logic          clk = 1'b0;
  logic          cpu_resetn = 1'b1;
  logic          end_of_write = 1'b0;
  logic          start = 1'b0;
  logic          rd_busy = 1'b0;
  logic          rd_data_valid = 1'b0;
  logic [127:0]  rd_data = '0;
  logic          rd_en;
  logic [23:0]   rd_addr;
  logic [23:0]   pixel_out;
  logic          pixel_valid;
  logic          pixel_ready = 1'b0;
  logic          end_of_frame;
  logic          full_read_ready;
  logic [8:0]    frame_number;

  ddr_frame_reader #(
    .MAX_ADDRESS      (MA),
    .NUMBER_OF_PIXELS (NP),
    .PIXEL_WIDTH      (PW),
    .NUMBER_OF_FRAMES (NF)
  ) dut (
    .clk             (clk),
    .cpu_resetn      (cpu_resetn),
    .end_of_write    (end_of_write),
    .start           (start),
    .rd_busy         (rd_busy),
    .rd_data_valid   (rd_data_valid),
    .rd_data         (rd_data),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .pixel_out       (pixel_out),
    .pixel_valid     (pixel_valid),
    .pixel_ready     (pixel_ready),
    .end_of_frame    (end_of_frame),
    .full_read_ready (full_read_ready),
    .frame_number    (frame_number)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] pix;
    logic        eof;
    logic        last;
    logic [8:0]  frame;
  } exp_t;

  typedef struct {
    int lat;
    bit rnd;
    int pix;
    int frr;
    int reads;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Stimulus controls (written only by the main sequence).
  int   lat = 2;
  bit   rnd_ready = 1'b0;
  int   inject_req = 0;
  int   inject_mode = 0;

  // Model state (written only by the model process).
  int   inject_done = 0;
  int   pend_cnt = 0;
  int   pend_addr = 0;
  int   exp_addr = 0;
  int   n_reads = 0;
  int   n_pix = 0;
  int   n_frr = 0;
  bit   expect_frr = 1'b0;
  bit   expect_pv = 1'b0;
  bit   prev_stall = 1'b0;
  bit   prev_rd_en = 1'b0;
  logic [23:0] prev_pix = '0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [23:0] pix_of(input int a, input int k);
    return 24'hA00000 + 24'(a * 8 + k);
  endfunction

  function automatic logic [127:0] word_of(input int a);
    logic [127:0] w;
    w = '0;
    w[127:120] = 8'hFF;
    for (int k = 0; k < 5; k++) w[24*k +: 24] = pix_of(a, k);
    return w;
  endfunction

  // Expected pixels of one word: the last word of a frame only carries the frame remainder.
  function automatic void push_word(input int a);
    exp_t e;
    int w, f, n;
    w = a % MA;
    f = (a / MA) % NF;
    n = (w == MA - 1) ? NP - 5 * (MA - 1) : 5;
    for (int k = 0; k < n; k++) begin
      e.pix   = pix_of(a, k);
      e.eof   = (w == MA - 1) && (k == n - 1);
      e.last  = e.eof && (f == NF - 1);
      e.frame = 9'(f);
      sb.push_back(e);
    end
  endfunction

  // Consumer, scoreboard and DDR read model, all evaluated on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!cpu_resetn) begin
      sb.delete();
      pend_cnt      = 0;
      exp_addr      = 0;
      expect_frr    = 1'b0;
      expect_pv     = 1'b0;
      prev_stall    = 1'b0;
      prev_rd_en    = 1'b0;
      rd_data_valid = 1'b0;
      pixel_ready   = 1'b0;
      inject_done   = inject_req;
    end else begin
      pixel_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (expect_pv) check("first_pixel_latency", 32'(pixel_valid), 32'(1));
      expect_pv = 1'b0;
      check("full_read_ready", 32'(full_read_ready), 32'(expect_frr));
      expect_frr = 1'b0;
      if (prev_stall) begin
        check("stall_valid", 32'(pixel_valid), 32'(1));
        check("stall_pixel", 32'(pixel_out), 32'(prev_pix));
      end
      if (pixel_valid && pixel_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pixel", 32'(pixel_out), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("pixel", 32'(pixel_out), 32'(e.pix));
          check("end_of_frame", 32'(end_of_frame), 32'(e.eof));
          check("frame_number", 32'(frame_number), 32'(e.frame));
          expect_frr = e.last;
          n_pix++;
        end
      end
      prev_stall = pixel_valid && !pixel_ready;
      prev_pix   = pixel_out;
      if (full_read_ready) n_frr++;

      rd_data_valid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          rd_data_valid = 1'b1;
          rd_data       = word_of(pend_addr);
          push_word(pend_addr);
          expect_pv     = 1'b1;
        end
      end else if (inject_req != inject_done && (inject_mode == 2 || pixel_valid)) begin
        rd_data_valid = 1'b1;
        rd_data       = {4{32'hDEAD_BEEF}};
        inject_done++;
      end
      if (rd_en) begin
        check("rd_en_single", 32'(prev_rd_en), 32'(0));
        check("rd_addr", 32'(rd_addr), 32'(exp_addr));
        pend_addr = exp_addr;
        pend_cnt  = lat;
        exp_addr  = (exp_addr + 1) % WORDS;
        n_reads++;
      end
      prev_rd_en = rd_en;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    cpu_resetn   = 1'b0;
    start        = 1'b0;
    end_of_write = 1'b0;
    rd_busy      = 1'b0;
    repeat (2) @(negedge clk);
    cpu_resetn = 1'b1;
  endtask

  task automatic wait_pix(input int target, input string nm);
    int c;
    c = 0;
    while (n_pix < target && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (n_pix < target) check({"timeout_", nm}, 32'(n_pix), 32'(target));
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "_rd_en"}, 32'(rd_en), 32'(0));
    check({nm, "_rd_addr"}, 32'(rd_addr), 32'(0));
    check({nm, "_pixel_out"}, 32'(pixel_out), 32'(0));
    check({nm, "_pixel_valid"}, 32'(pixel_valid), 32'(0));
    check({nm, "_end_of_frame"}, 32'(end_of_frame), 32'(0));
    check({nm, "_full_read_ready"}, 32'(full_read_ready), 32'(0));
    check({nm, "_frame_number"}, 32'(frame_number), 32'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[3];
    int p0, f0, r0, seen, rd_got;
    vecs[0] = '{2, 1'b0, 26, 1, 6};
    vecs[1] = '{1, 1'b1, 26, 1, 6};
    vecs[2] = '{4, 1'b1, 26, 1, 6};

    #1 cpu_resetn = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    cpu_resetn = 1'b1;

    // Full sequences under different latencies and consumer behaviour.
    for (int i = 0; i < 3; i++) begin
      do_reset();
      lat       = vecs[i].lat;
      rnd_ready = vecs[i].rnd;
      p0 = n_pix; f0 = n_frr; r0 = n_reads;
      start = 1'b1; end_of_write = 1'b1;
      wait_pix(p0 + vecs[i].pix, "row");
      start  = 1'b0;
      rd_got = n_reads - r0;
      check("row_sb_empty", 32'(sb.size()), 32'(0));
      repeat (3) @(negedge clk);
      check("row_pixels", 32'(n_pix - p0), 32'(vecs[i].pix));
      check("row_reads", 32'(rd_got), 32'(vecs[i].reads));
      check("row_frr", 32'(n_frr - f0), 32'(vecs[i].frr));
    end

    // Start without end_of_write must not read.
    do_reset();
    rnd_ready = 1'b0; lat = 2;
    start = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge clk); if (rd_en) seen++; end
    check("no_read_without_eow", 32'(seen), 32'(0));
    end_of_write = 1'b1;
    seen = 0;
    repeat (2) begin @(negedge clk); if (rd_en) seen = 1; end
    check("read_after_eow", 32'(seen), 32'(1));

    // Controller busy holds the request back.
    do_reset();
    rd_busy = 1'b1; start = 1'b1; end_of_write = 1'b1;
    seen = 0;
    repeat (10) begin @(negedge clk); if (rd_en) seen++; end
    check("no_read_while_busy", 32'(seen), 32'(0));
    rd_busy = 1'b0;
    @(negedge clk);
    check("rd_en_after_busy", 32'(rd_en), 32'(1));
    @(negedge clk);
    check("rd_en_one_pulse", 32'(rd_en), 32'(0));

    // Stray rd_data_valid while unpacking.
    do_reset();
    rnd_ready = 1'b1; lat = 3;
    p0 = n_pix;
    start = 1'b1; end_of_write = 1'b1;
    wait_pix(p0 + 2, "spurious_pre");
    inject_mode = 1;
    inject_req++;
    wait_pix(p0 + 26, "spurious");
    check("spurious_injected", 32'(inject_req - inject_done), 32'(0));

    // Asynchronous reset mid-word, then a stray valid while idle.
    do_reset();
    rnd_ready = 1'b0; lat = 2;
    p0 = n_pix;
    start = 1'b1; end_of_write = 1'b1;
    wait_pix(p0 + 7, "midword");
    #2 cpu_resetn = 1'b0;
    #1 check_outputs_zero("async_reset");
    start = 1'b0;
    repeat (2) @(negedge clk);
    cpu_resetn = 1'b1;
    inject_mode = 2;
    inject_req++;
    seen = 0;
    repeat (4) begin @(negedge clk); if (pixel_valid || rd_en) seen++; end
    check("idle_ignores_valid", 32'(seen), 32'(0));
    inject_mode = 1;
    p0 = n_pix;
    start = 1'b1;
    wait_pix(p0 + 26, "restart");
    start = 1'b0;

    // Behaviour after a completed sequence with start low.
    r0 = n_reads;
    repeat (20) @(negedge clk);
`ifdef LOOP_PLAYBACK_EN
    check("loop_replay", 32'(n_reads - r0 > 0), 32'(1));
`else
    check("idle_after_sequence", 32'(n_reads - r0), 32'(0));
    start = 1'b1;
    seen = 0;
    repeat (3) begin @(negedge clk); if (rd_en) seen = 1; end
    check("replay_on_start", 32'(seen), 32'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
